// File: rtl/hub_pkg.sv
// hub_pkg
//   Shared definitions for hub_row_loader and its row buffer:
//   - display geometry (colours, pixel width, columns, rows, segments)
//   - status window addresses
//   - commit FSM state encoding
package hub_pkg;

  localparam int COLOR_COUNT   = 3;
  localparam int COLOR_BITS    = 4;
  localparam int COL_ADDR_BITS = 6;
  localparam int ROW_ADDR_BITS = 4;
  localparam int SEGMENT_COUNT = 2;

  localparam int NUM_COL       = 1 << COL_ADDR_BITS;
  localparam int SEG_BITS      = (SEGMENT_COUNT > 1) ? $clog2(SEGMENT_COUNT) : 1;
  localparam int PIXEL_WIDTH   = COLOR_BITS * COLOR_COUNT;
  localparam int ROW_DAT_WIDTH = NUM_COL * PIXEL_WIDTH;

  // Pixel-window address layout: {seg field, row, col}. The seg field spans
  // every bit up to addr[14] so that out-of-range segments are detectable
  // even when SEG_BITS cannot encode them.
  localparam int SEG_LSB       = COL_ADDR_BITS + ROW_ADDR_BITS;
  localparam int SEG_FIELD_W   = 15 - SEG_LSB;

  localparam logic [15:0] ADDR_COMMIT_COUNT = 16'h8000;
  localparam logic [15:0] ADDR_STATUS       = 16'h8001;
  localparam logic [15:0] ADDR_FLUSH        = 16'h8002;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/hub_row_buffer.sv
// hub_row_buffer
//   Pixel storage for one display row plus the column-valid mask.
//   Ports:
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     i_we            store i_pixel at column i_col and mark the column valid
//     i_col, i_pixel  write column and pixel value
//     i_clear         clear the column mask (pixel contents are kept)
//     o_mask          column-valid mask
//     o_row_data      flattened row, pixel j at [(j+1)*PIXEL_WIDTH-1 : j*PIXEL_WIDTH]
module hub_row_buffer
  import hub_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_we,
  input  logic [COL_ADDR_BITS-1:0] i_col,
  input  logic [PIXEL_WIDTH-1:0]   i_pixel,
  input  logic                     i_clear,
  output logic [NUM_COL-1:0]       o_mask,
  output logic [ROW_DAT_WIDTH-1:0] o_row_data
);

  logic [PIXEL_WIDTH-1:0] r_pix [NUM_COL];
  logic [NUM_COL-1:0]     r_mask;

  // Pixel contents survive a commit; only reset zeroes them, so a partial
  // commit carries whatever the unwritten columns last held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < NUM_COL; j++) r_pix[j] <= '0;
    end else if (i_we) begin
      r_pix[i_col] <= i_pixel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= '0;
    end else if (i_clear) begin
      r_mask <= '0;
    end else if (i_we) begin
      r_mask[i_col] <= 1'b1;
    end
  end

  for (genvar j = 0; j < NUM_COL; j++) begin : g_flat
    assign o_row_data[j*PIXEL_WIDTH +: PIXEL_WIDTH] = r_pix[j];
  end

  assign o_mask = r_mask;

endmodule

// File: rtl/hub_row_loader.sv
// hub_row_loader
//   Wishbone slave collecting host pixel writes into a row buffer and
//   committing complete (or flushed / displaced) rows to the segment row RAMs.
//   Optional feature macro: HUB_LOADER_STATUS_EN (commit/drop counters and
//   status reads; without it every read returns 0).
//   Ports:
//     clk, gls_reset_n          clock, asynchronous active-low reset
//     wbm_address/writedata     word address, write data (pixel in low bits)
//     wbm_strobe/cycle/write    Wishbone classic controls
//     wbm_readdata, wbm_ack     read data, single-cycle acknowledge
//     ram_w_en                  one-hot segment write strobe
//     ram_w_addr, ram_w_data    row index and flattened row, valid with ram_w_en
//     busy                      high during the commit cycle
//
//   state     | meaning
//   ST_IDLE   | evaluate bus requests; start commit when the row is full
//   ST_COMMIT | one-cycle RAM write of the buffered row, clear the mask
module hub_row_loader
  import hub_pkg::*;
(
  input  logic                     clk,
  input  logic                     gls_reset_n,
  input  logic [15:0]              wbm_address,
  input  logic [15:0]              wbm_writedata,
  output logic [15:0]              wbm_readdata,
  input  logic                     wbm_strobe,
  input  logic                     wbm_cycle,
  input  logic                     wbm_write,
  output logic                     wbm_ack,
  output logic [SEGMENT_COUNT-1:0] ram_w_en,
  output logic [ROW_ADDR_BITS-1:0] ram_w_addr,
  output logic [ROW_DAT_WIDTH-1:0] ram_w_data,
  output logic                     busy
);

  localparam logic [SEG_FIELD_W-1:0] SEG_LIMIT = SEG_FIELD_W'(SEGMENT_COUNT);

  state_t                   r_state, w_state_nxt;
  logic                     r_ack, w_ack_nxt;
  logic [15:0]              r_rdata, w_rdata_nxt;
  logic [ROW_ADDR_BITS-1:0] r_buf_row;
  logic [SEG_BITS-1:0]      r_buf_seg;

  logic                     w_req, w_pix_we, w_drop_inc, w_commit;
  logic                     w_dirty, w_full, w_seg_ok;
  logic [NUM_COL-1:0]       w_mask;
  logic [ROW_DAT_WIDTH-1:0] w_row_data;
  logic [COL_ADDR_BITS-1:0] w_col;
  logic [ROW_ADDR_BITS-1:0] w_row;
  logic [SEG_FIELD_W-1:0]   w_seg_field;
  logic [SEG_BITS-1:0]      w_seg;
  logic [15:0]              w_status_rdata;
  logic                     w_unused;

  // Masking with the ack keeps the ack a single-cycle pulse while the master
  // still holds strobe during the ack cycle.
  assign w_req       = wbm_cycle & wbm_strobe & ~r_ack;
  assign w_col       = wbm_address[COL_ADDR_BITS-1:0];
  assign w_row       = wbm_address[SEG_LSB-1:COL_ADDR_BITS];
  assign w_seg_field = wbm_address[14:SEG_LSB];
  assign w_seg       = w_seg_field[SEG_BITS-1:0];
  assign w_seg_ok    = (w_seg_field < SEG_LIMIT);
  assign w_dirty     = |w_mask;
  assign w_full      = &w_mask;
  assign w_unused    = &{1'b0, wbm_writedata[15:PIXEL_WIDTH]};

  hub_row_buffer u_row_buffer (
    .i_clk      (clk),
    .i_rst_n    (gls_reset_n),
    .i_we       (w_pix_we),
    .i_col      (w_col),
    .i_pixel    (wbm_writedata[PIXEL_WIDTH-1:0]),
    .i_clear    (w_commit),
    .o_mask     (w_mask),
    .o_row_data (w_row_data)
  );

`ifdef HUB_LOADER_STATUS_EN
  logic [15:0] r_commit_count;
  logic [7:0]  r_drop_count;

  always_ff @(posedge clk or negedge gls_reset_n) begin
    if (!gls_reset_n) begin
      r_commit_count <= '0;
      r_drop_count   <= '0;
    end else begin
      if (w_commit) r_commit_count <= r_commit_count + 16'd1;
      if (w_drop_inc && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  always_comb begin
    w_status_rdata = '0;
    if (wbm_address == ADDR_COMMIT_COUNT) w_status_rdata = r_commit_count;
    else if (wbm_address == ADDR_STATUS)  w_status_rdata = {r_drop_count, 7'b0, w_dirty};
  end
`else
  logic w_unused_stat;
  assign w_unused_stat  = w_drop_inc;
  assign w_status_rdata = '0;
`endif

  always_ff @(posedge clk or negedge gls_reset_n) begin
    if (!gls_reset_n) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_rdata_nxt = '0;
    w_pix_we    = 1'b0;
    w_drop_inc  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A full mask is seen in the ack cycle of the completing write, where
        // w_req is already masked, so no request is lost here.
        if (w_full) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_req) begin
          if (wbm_address[15]) begin
            w_ack_nxt = 1'b1;
            if (!wbm_write) w_rdata_nxt = w_status_rdata;
            else if ((wbm_address == ADDR_FLUSH) && w_dirty) w_state_nxt = ST_COMMIT;
          end else if (!wbm_write) begin
            w_ack_nxt = 1'b1;
          end else if (!w_seg_ok) begin
            w_ack_nxt  = 1'b1;
            w_drop_inc = 1'b1;
          end else if (w_dirty && ({w_seg, w_row} != {r_buf_seg, r_buf_row})) begin
            // Row change: commit first, the request stays pending unacked.
            w_state_nxt = ST_COMMIT;
          end else begin
            w_ack_nxt = 1'b1;
            w_pix_we  = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge gls_reset_n) begin
    if (!gls_reset_n) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_buf_row <= '0;
      r_buf_seg <= '0;
    end else begin
      r_ack   <= w_ack_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_pix_we) begin
        r_buf_row <= w_row;
        r_buf_seg <= w_seg;
      end
    end
  end

  // Row address and data come straight from registered buffer state, which
  // cannot change during COMMIT; the strobe decodes the state register so an
  // asynchronous reset drops it at once.
  assign busy         = (r_state == ST_COMMIT);
  assign ram_w_en     = busy ? (SEGMENT_COUNT'(1) << r_buf_seg) : '0;
  assign ram_w_addr   = r_buf_row;
  assign ram_w_data   = w_row_data;
  assign wbm_ack      = r_ack;
  assign wbm_readdata = r_rdata;

endmodule
